// File: rtl/fifo_pkt_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkt_reader_pkg
// Brief   : Shared ctrl-word encodings and framing state type for the reader.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_pkt_reader_pkg;

    localparam logic [7:0] CTRL_MODULE_HDR = 8'hFF;
    localparam logic [7:0] CTRL_DATA       = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_pkt_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkt_reader_if
// Brief   : FIFO read side plus packet output bus of the packet reader.
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_pkt_reader_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = 8,
    parameter int PKT_CNT_WIDTH = 16
);
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic                             fifo_empty;
    logic                             fifo_rd_en;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic                             pkt_done;
    logic [PKT_CNT_WIDTH-1:0]         pkt_count;
    logic                             proto_err;

    modport master (
        input  fifo_dout, fifo_empty, out_rdy,
        output fifo_rd_en, out_data, out_ctrl, out_wr, pkt_done, pkt_count, proto_err
    );

    modport slave (
        output fifo_dout, fifo_empty, out_rdy,
        input  fifo_rd_en, out_data, out_ctrl, out_wr, pkt_done, pkt_count, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/fifo_pkt_reader_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkt_reader_skid_buf
// Brief   : 2-entry hold buffer absorbing the FIFO read latency.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_pkt_reader_skid_buf #(
    parameter int WIDTH = 72
)(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head,
    output logic      [1:0]       o_count
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Upstream issue logic guarantees a write never lands on a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_wr) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_wr} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkt_reader
// Brief   : Drains a registered-output FIFO onto the packet bus, tracking framing.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_pkt_reader #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = 8,
    parameter int PKT_CNT_WIDTH = 16
)(
    input  wire logic         clk,
    input  wire logic         reset,
    fifo_pkt_reader_if.master bus
);
    import fifo_pkt_reader_pkg::*;

    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;

    logic [WORD_W-1:0]        w_head;
    logic [1:0]               w_count;
    logic                     w_pop;
    logic [2:0]               w_fill;
    logic [CTRL_WIDTH-1:0]    w_ctrl;

    logic                     r_rd_pending;
    frame_state_t             r_state;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [CTRL_WIDTH-1:0]    r_out_ctrl;
    logic                     r_out_wr;
    logic                     r_pkt_done;
    logic [PKT_CNT_WIDTH-1:0] r_pkt_count;
    logic                     r_proto_err;

    fifo_pkt_reader_skid_buf #(
        .WIDTH (WORD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_wr    (r_rd_pending),
        .i_din   (bus.fifo_dout),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_pop  = bus.out_rdy && (w_count != 2'd0);
    assign w_ctrl = w_head[WORD_W-1 -: CTRL_WIDTH];

    // Occupancy after this edge, counting the word already in flight from the FIFO.
    assign w_fill = {1'b0, w_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};
    assign bus.fifo_rd_en = !reset && !bus.fifo_empty && (w_fill < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pending <= 1'b0;
            r_state      <= ST_IDLE;
            r_out_data   <= '0;
            r_out_ctrl   <= '0;
            r_out_wr     <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_count  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_rd_pending <= bus.fifo_rd_en;
            r_out_wr     <= w_pop;
            r_pkt_done   <= 1'b0;
            if (w_pop) begin
                r_out_data <= w_head[DATA_WIDTH-1:0];
                r_out_ctrl <= w_ctrl;
                case (r_state)
                    ST_IDLE: begin
                        if (w_ctrl == CTRL_MODULE_HDR) r_state     <= ST_HDR;
                        else                           r_proto_err <= 1'b1;
                    end
                    ST_HDR: begin
                        if (w_ctrl == CTRL_DATA) begin
                            r_state <= ST_PAYLOAD;
                        end else if (w_ctrl != CTRL_MODULE_HDR) begin
                            // Malformed header run still closes the packet.
                            r_proto_err <= 1'b1;
                            r_pkt_done  <= 1'b1;
                            r_pkt_count <= r_pkt_count + PKT_CNT_WIDTH'(1);
                            r_state     <= ST_IDLE;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (w_ctrl != CTRL_DATA) begin
                            r_pkt_done  <= 1'b1;
                            r_pkt_count <= r_pkt_count + PKT_CNT_WIDTH'(1);
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ctrl  = r_out_ctrl;
    assign bus.out_wr    = r_out_wr;
    assign bus.pkt_done  = r_pkt_done;
    assign bus.pkt_count = r_pkt_count;
    assign bus.proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_pkt_reader
// Brief   : Scoreboard bench for fifo_pkt_reader with a 2-bit packet counter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_pkt_reader;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int PW = 2;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic          done;
        logic [PW-1:0] cnt;
        logic          err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rdy_q = 1'b0;

    always #5 clk = ~clk;

    fifo_pkt_reader_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .PKT_CNT_WIDTH(PW)) bus ();

    fifo_pkt_reader #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .PKT_CNT_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [CW+DW-1:0] fq [$];
    exp_t             sb [$];
    int               n_checks = 0;
    int               n_errors = 0;

    int            m_st  = 0;
    logic          m_err = 1'b0;
    logic [PW-1:0] m_cnt = '0;
    exp_t          mon_e;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference framing model: 0 idle, 1 header run, 2 payload.
    task automatic send(input logic [7:0] c, input logic [63:0] d);
        exp_t e;
        logic eop = 1'b0;
        case (m_st)
            0: if (c == 8'hFF) m_st = 1; else m_err = 1'b1;
            1: if (c == 8'h00) m_st = 2;
               else if (c != 8'hFF) begin m_err = 1'b1; eop = 1'b1; end
            default: if (c != 8'h00) eop = 1'b1;
        endcase
        if (eop) begin
            m_cnt = m_cnt + 1'b1;
            m_st  = 0;
        end
        e.ctrl = c; e.data = d; e.done = eop; e.cnt = m_cnt; e.err = m_err;
        sb.push_back(e);
        fq.push_back({c, d});
    endtask

    task automatic drain(input string tag, input int maxc, input bit toggle);
        for (int c = 0; c < maxc && sb.size() != 0; c++) begin
            @(negedge clk);
            if (toggle) bus.out_rdy = ((c / 2) % 2) == 0;
        end
        bus.out_rdy = 1'b1;
        check(tag, 72'(sb.size()), 72'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        check("rst_out_wr",    72'(bus.out_wr),    72'd0);
        check("rst_out_data",  72'(bus.out_data),  72'd0);
        check("rst_out_ctrl",  72'(bus.out_ctrl),  72'd0);
        check("rst_pkt_done",  72'(bus.pkt_done),  72'd0);
        check("rst_pkt_count", 72'(bus.pkt_count), 72'd0);
        check("rst_proto_err", 72'(bus.proto_err), 72'd0);
        fq.delete();
        sb.delete();
        m_st = 0; m_err = 1'b0; m_cnt = '0;
        reset = 1'b0;
    endtask

    // FIFO model: registered read data, one cycle after rd_en.
    always @(posedge clk) begin
        rdy_q <= bus.out_rdy;
        if (bus.fifo_rd_en) begin
            check("rd_nonempty", 72'(fq.size() != 0), 72'd1);
            if (fq.size() != 0) bus.fifo_dout <= fq.pop_front();
        end
    end

    always @(negedge clk) begin
        #1;
        bus.fifo_empty = (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_wr) begin
                check("wr_after_rdy", 72'(rdy_q), 72'd1);
                check("sb_has_entry", 72'(sb.size() != 0), 72'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("out_data",  72'(bus.out_data),  72'(mon_e.data));
                    check("out_ctrl",  72'(bus.out_ctrl),  72'(mon_e.ctrl));
                    check("pkt_done",  72'(bus.pkt_done),  72'(mon_e.done));
                    check("pkt_count", 72'(bus.pkt_count), 72'(mon_e.cnt));
                    check("proto_err", 72'(bus.proto_err), 72'(mon_e.err));
                end
            end else begin
                check("done_idle", 72'(bus.pkt_done), 72'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        int first_rd, first_wr, last_wr, nwr;
        bus.out_rdy = 1'b0;

        // Reset held with a non-empty FIFO
        @(negedge clk);
        fq.push_back({8'hFF, 64'h1});
        fq.push_back({8'h04, 64'h2});
        repeat (3) begin
            @(negedge clk);
            check("rst_rd_en", 72'(bus.fifo_rd_en), 72'd0);
        end
        do_reset(1);

        // Streaming packet with latency and back-to-back check
        bus.out_rdy = 1'b1;
        send(8'hFF, 64'hAAAA_0000_0000_0001);
        send(8'h00, 64'h0000_0000_0000_D000);
        send(8'h00, 64'h0000_0000_0000_D001);
        send(8'h00, 64'h0000_0000_0000_D002);
        send(8'h04, 64'h0000_0000_0000_D003);
        first_rd = -1; first_wr = -1; last_wr = -1; nwr = 0;
        for (int c = 0; c < 15; c++) begin
            #2;
            if (bus.fifo_rd_en && first_rd < 0) first_rd = c;
            if (bus.out_wr) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                nwr++;
            end
            @(negedge clk);
        end
        check("stream_latency", 72'(first_wr - first_rd), 72'd3);
        check("stream_words",   72'(nwr),                 72'd5);
        check("stream_span",    72'(last_wr - first_wr),  72'd4);
        check("stream_drained", 72'(sb.size()),           72'd0);

        // 20-word packet under toggling backpressure
        send(8'hFF, 64'hBBBB);
        for (int i = 0; i < 18; i++) send(8'h00, 64'(32'hC000 + i));
        send(8'h01, 64'hCFFF);
        drain("bp_drain", 300, 1'b1);

        // Framing errors: stray data in IDLE, bad header run
        send(8'h00, 64'hE0);
        send(8'hFF, 64'hE1);
        send(8'h00, 64'hE2);
        send(8'h01, 64'hE3);
        send(8'hFF, 64'hE4);
        send(8'h03, 64'hE5);
        send(8'hFF, 64'hE6);
        send(8'h00, 64'hE7);
        send(8'h02, 64'hE8);
        drain("err_drain", 100, 1'b0);

        // Reset mid-packet with the hold buffer full
        bus.out_rdy = 1'b0;
        send(8'hFF, 64'hF0);
        for (int i = 0; i < 4; i++) send(8'h00, 64'(32'hF1 + i));
        send(8'h01, 64'hF9);
        repeat (8) @(negedge clk);
        check("stall_rd_en", 72'(bus.fifo_rd_en), 72'd0);
        check("stall_out_wr", 72'(bus.out_wr), 72'd0);
        do_reset(1);
        bus.out_rdy = 1'b1;
        send(8'hFF, 64'h100);
        send(8'h00, 64'h101);
        send(8'h05, 64'h102);
        drain("post_rst_drain", 50, 1'b0);

        // Counter wrap with 2-bit counter
        do_reset(2);
        for (int p = 0; p < 5; p++) begin
            send(8'hFF, 64'(32'h200 + p));
            send(8'h00, 64'(32'h300 + p));
            send(8'h01, 64'(32'h400 + p));
        end
        drain("wrap_drain", 100, 1'b0);
        check("wrap_final_count", 72'(bus.pkt_count), 72'd1);
        check("wrap_proto_err",   72'(bus.proto_err), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
